// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter and its grant logic.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin grant selection with a streak guard that bounds
// how many data grants can pass a waiting fetch.
module rr_pick
    import mem_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1)
) (
    input  logic                i_req,
    input  logic                d_req,
    input  owner_t              last_owner,
    input  logic [STREAK_W-1:0] data_streak,
    output logic                pick_valid,
    output owner_t              pick
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        pick_valid = i_req | d_req;
        pick       = OWN_FETCH;
        // Data keeps priority until its streak budget is spent; a full streak
        // always follows a data grant, so fetch then wins the tie.
        if (d_req && (!i_req || last_owner == OWN_FETCH || data_streak < STREAK_MAX)) begin
            pick = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port memory between instruction fetch and the load/store
// unit: one access every three cycles through IDLE -> ACCESS -> RESP.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_read_address,
    output logic [2:0]  mem_funct3,
    output logic        mem_write_mem,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic [STREAK_W-1:0] data_streak_q, data_streak_d;
    logic [31:0]         read_address_q, read_address_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                write_mem_q, write_mem_d;
    logic [31:0]         write_address_q, write_address_d;
    logic [31:0]         write_data_q, write_data_d;

    logic   pick_valid;
    owner_t pick;

    rr_pick #(.MAX_DATA_BURST(MAX_DATA_BURST)) u_rr_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner_q),
        .data_streak (data_streak_q),
        .pick_valid  (pick_valid),
        .pick        (pick)
    );

    assign i_gnt = (state_q == IDLE) && pick_valid && (pick == OWN_FETCH);
    assign d_gnt = (state_q == IDLE) && pick_valid && (pick == OWN_DATA);

    assign i_rvalid = (state_q == RESP) && (owner_q == OWN_FETCH);
    assign d_rvalid = (state_q == RESP) && (owner_q == OWN_DATA);
    assign i_rdata  = i_rvalid ? mem_read_data : 32'd0;
    assign d_rdata  = d_rvalid ? mem_read_data : 32'd0;

    assign mem_read_address  = read_address_q;
    assign mem_funct3        = funct3_q;
    assign mem_write_mem     = write_mem_q;
    assign mem_write_address = write_address_q;
    assign mem_write_data    = write_data_q;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        data_streak_d   = data_streak_q;
        read_address_d  = read_address_q;
        funct3_d        = funct3_q;
        write_mem_d     = write_mem_q;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = ACCESS;
                    owner_d      = pick;
                    last_owner_d = pick;
                    if (pick == OWN_FETCH) begin
                        read_address_d  = i_addr;
                        write_address_d = i_addr;
                        funct3_d        = FUNCT3_WORD;
                        write_mem_d     = 1'b0;
                        write_data_d    = 32'd0;
                        data_streak_d   = '0;
                    end else begin
                        read_address_d  = d_addr;
                        write_address_d = d_addr;
                        funct3_d        = d_funct3;
                        write_mem_d     = d_we;
                        write_data_d    = d_wdata;
                        if (i_req && data_streak_q < STREAK_MAX) begin
                            data_streak_d = data_streak_q + 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                // Address and funct3 stay put through RESP for the negedge sample.
                state_d     = RESP;
                write_mem_d = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset clears write_mem asynchronously so a store caught in ACCESS never reaches memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_FETCH;
            last_owner_q    <= OWN_FETCH;
            data_streak_q   <= '0;
            read_address_q  <= 32'd0;
            funct3_q        <= 3'd0;
            write_mem_q     <= 1'b0;
            write_address_q <= 32'd0;
            write_data_q    <= 32'd0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            data_streak_q   <= data_streak_d;
            read_address_q  <= read_address_d;
            funct3_q        <= funct3_d;
            write_mem_q     <= write_mem_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory with a millis counter,
// a reference arbitration model and a response scoreboard.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int MAX0 = 4;
    localparam int MAX1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_funct3;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
    logic [2:0]  mem_funct3;
    logic        mem_write_mem;

    logic        u1_i_gnt, u1_i_rvalid, u1_d_gnt, u1_d_rvalid, u1_we;
    logic [31:0] u1_i_rdata, u1_d_rdata, u1_ra, u1_wa, u1_wd;
    logic [2:0]  u1_f3;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DATA_BURST(MAX0)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_read_address(mem_read_address), .mem_funct3(mem_funct3),
        .mem_write_mem(mem_write_mem), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Second instance with a burst budget of one, run in lockstep for grant order only.
    mem_arbiter #(.MAX_DATA_BURST(MAX1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(u1_i_gnt), .i_rvalid(u1_i_rvalid), .i_rdata(u1_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(u1_d_gnt), .d_rvalid(u1_d_rvalid), .d_rdata(u1_d_rdata),
        .mem_read_address(u1_ra), .mem_funct3(u1_f3),
        .mem_write_mem(u1_we), .mem_write_address(u1_wa),
        .mem_write_data(u1_wd), .mem_read_data(32'd0)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [7:0]  mem [1024];
    logic        mem_loaded = 1'b0;
    int          mem_cnt;
    logic [31:0] ra_q;
    logic [2:0]  f3_q;
    logic [9:0]  wix;

    function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] f3);
        logic [9:0] ix;
        logic [7:0] b0, b1, b2, b3;
        if (a == 32'hFFFF_FFF8) return 32'(mem_cnt / 12000);
        ix = a[9:0];
        b0 = mem[ix];
        b1 = mem[ix + 10'd1];
        b2 = mem[ix + 10'd2];
        b3 = mem[ix + 10'd3];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign wix = mem_write_address[9:0];

    always @(posedge clk) begin
        if (rst) begin
            mem_cnt <= 0;
            if (!mem_loaded) begin
                for (int k = 0; k < 1024; k++) mem[k] <= 8'h00;
                mem[16] <= 8'h93; mem[17] <= 8'h00; mem[18] <= 8'h50; mem[19] <= 8'h00;
                mem_loaded <= 1'b1;
            end
        end else begin
            mem_cnt <= mem_cnt + 1;
            if (mem_write_mem) begin
                mem[wix] <= mem_write_data[7:0];
                if (mem_funct3[1:0] != 2'b00) mem[wix + 10'd1] <= mem_write_data[15:8];
                if (mem_funct3[1:0] == 2'b10) begin
                    mem[wix + 10'd2] <= mem_write_data[23:16];
                    mem[wix + 10'd3] <= mem_write_data[31:24];
                end
            end
            ra_q <= mem_read_address;
            f3_q <= mem_funct3;
        end
    end

    always_comb mem_read_data = rd(ra_q, f3_q);

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        owner_t      own;
        logic        store;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] exp_i_data, exp_d_data;
    int          n_cyc = 0;
    int          m_phase, m_streak, m1_streak;
    logic        m_store;

    always @(negedge clk) begin
        logic ev, e_i, e_d, ei, ed, ei1, ed1;
        resp_t r;
        n_cyc++;
        if (rst) begin
            sb.delete();
            m_phase = 0; m_streak = 0; m1_streak = 0; m_store = 1'b0;
        end else begin
            ev  = (sb.size() > 0) && (sb[0].due == n_cyc);
            e_i = ev && sb[0].own == OWN_FETCH;
            e_d = ev && sb[0].own == OWN_DATA;
            check("i_rvalid", 32'(i_rvalid), 32'(e_i));
            check("d_rvalid", 32'(d_rvalid), 32'(e_d));
            check("i_rdata", i_rdata, e_i ? sb[0].data : 32'd0);
            if (e_d && !sb[0].store) check("d_rdata", d_rdata, sb[0].data);
            else if (!e_d)           check("d_rdata_idle", d_rdata, 32'd0);
            if (ev) void'(sb.pop_front());
            check("mem_write_mem", 32'(mem_write_mem), 32'(m_phase == 1 && m_store));

            ei = 1'b0; ed = 1'b0; ei1 = 1'b0; ed1 = 1'b0;
            if (m_phase == 0) begin
                ed  = d_req && (!i_req || m_streak < MAX0);
                ei  = i_req && !ed;
                ed1 = d_req && (!i_req || m1_streak < MAX1);
                ei1 = i_req && !ed1;
            end
            check("i_gnt", 32'(i_gnt), 32'(ei));
            check("d_gnt", 32'(d_gnt), 32'(ed));
            check("u1_i_gnt", 32'(u1_i_gnt), 32'(ei1));
            check("u1_d_gnt", 32'(u1_d_gnt), 32'(ed1));

            if (ei || ed) begin
                r.own   = ed ? OWN_DATA : OWN_FETCH;
                r.store = ed && d_we;
                r.data  = ed ? exp_d_data : exp_i_data;
                r.due   = n_cyc + 2;
                sb.push_back(r);
                m_store = ed && d_we;
                m_phase = 1;
                if (ei) m_streak = 0;
                else if (i_req && m_streak < MAX0) m_streak++;
                if (ei1) m1_streak = 0;
                else if (i_req && m1_streak < MAX1) m1_streak++;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input logic for_data);
        int   k = 0;
        logic got = 1'b0;
        while (!got && k < 50) begin
            @(negedge clk);
            got = for_data ? d_gnt : i_gnt;
            k++;
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        exp_i_data = exp; i_addr = a; i_req = 1'b1;
        wait_gnt(1'b0);
        i_req = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic data_acc(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp);
        exp_d_data = exp; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_gnt(1'b1);
        d_req = 1'b0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        exp_i_data = 32'd0; exp_d_data = 32'd0;
        rst = 1'b1;
        #2;
        check("rst_write_mem", 32'(mem_write_mem), 32'd0);
        check("rst_read_addr", mem_read_address, 32'd0);
        do_reset();

        // Single fetch, then store byte and sign/zero-extended loads back.
        fetch(32'h10, 32'h0050_0093);
        data_acc(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 32'd0);
        data_acc(1'b0, 3'b100, 32'h101, 32'd0, 32'h0000_00AB);
        data_acc(1'b0, 3'b000, 32'h101, 32'd0, 32'hFFFF_FFAB);
        data_acc(1'b1, 3'b010, 32'h200, 32'h8765_4321, 32'd0);
        data_acc(1'b0, 3'b001, 32'h200, 32'd0, 32'h0000_4321);
        data_acc(1'b0, 3'b101, 32'h202, 32'd0, 32'h0000_8765);
        data_acc(1'b0, 3'b001, 32'h202, 32'd0, 32'hFFFF_8765);

        // Tie: both held from a fresh reset; burst budget 4 here and 1 on u_dut1.
        do_reset();
        exp_i_data = 32'h0050_0093; exp_d_data = 32'h0000_00AB;
        i_addr = 32'h10; d_addr = 32'h101; d_funct3 = 3'b100; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        repeat (33) @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Reset asserted mid-ACCESS of a store: no write, no response.
        exp_d_data = 32'd0; d_we = 1'b1; d_funct3 = 3'b010; d_addr = 32'h40;
        d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        wait_gnt(1'b1);
        d_req = 1'b0;
        #1 rst = 1'b1;
        #1 check("rst_cancels_write", 32'(mem_write_mem), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_mem_unchanged", {mem[67], mem[66], mem[65], mem[64]}, 32'd0);
        fetch(32'h10, 32'h0050_0093);

        // Millis peripheral pass-through after ~25000 cycles (reads 2).
        repeat (25000) @(posedge clk); #1;
        data_acc(1'b0, 3'b010, 32'hFFFF_FFF8, 32'd0, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
